// File: rtl/enc_buffer_fullness.sv
// Encoder-side rate-buffer fullness tracker, mirroring the decoder's buffer model block for block.
// Optional slice bit accumulator is built only when ENC_BUF_SLICE_BITS_EN is defined.
module enc_buffer_fullness #(
  parameter int          AVE_BLK_BITS    = 128,
  parameter int          INIT_DELAY_BLKS = 64,
  parameter logic [15:0] BUF_SIZE        = 16'd8192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        slice_start,
  input  logic        blk_valid,
  input  logic [9:0]  curBlkBits,
  input  logic        slice_end,
  output logic [15:0] m_bufferFullness,
  output logic [15:0] m_numPixelsCoded,
  output logic [15:0] m_numBlocksCoded,
  output logic [9:0]  padBits,
  output logic        underflow,
  output logic        overflow,
  output logic        flush_done,
  output logic        busy,
  output logic [31:0] m_sliceBitsCur
);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_STEADY, S_FLUSH} state_t;

  localparam logic [16:0] AVE17    = 17'(AVE_BLK_BITS);
  localparam logic [15:0] AVE16    = 16'(AVE_BLK_BITS);
  localparam logic [15:0] INIT_DLY = 16'(INIT_DELAY_BLKS);

  state_t      state_q, state_d;
  logic [15:0] full_q, full_d;
  logic [15:0] blks_q, blks_d;
  logic [15:0] pix_q, pix_d;
  logic [9:0]  pad_q, pad_d;
  logic        udf_q, udf_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;

  logic [15:0] base_full, base_blks, base_pix;
  logic        base_ovf;
  logic        accept;
  logic [16:0] sum, drain, res;
  logic [15:0] flush_res;

  // slice_start restarts from a clean slate, so a coincident block sees zeroed state.
  assign base_full = slice_start ? 16'd0 : full_q;
  assign base_blks = slice_start ? 16'd0 : blks_q;
  assign base_pix  = slice_start ? 16'd0 : pix_q;
  assign base_ovf  = slice_start ? 1'b0  : ovf_q;
  assign accept    = blk_valid &&
                     (slice_start || state_q == S_INIT || state_q == S_STEADY);
  assign sum       = {1'b0, base_full} + {7'd0, curBlkBits};
  assign drain     = (base_blks > INIT_DLY) ? AVE17 : 17'd0;
  assign flush_res = (full_q > AVE16) ? (full_q - AVE16) : 16'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (slice_start) begin
      state_d = (accept && base_blks == INIT_DLY) ? S_STEADY : S_INIT;
    end else begin
      case (state_q)
        S_IDLE:   state_d = S_IDLE;
        S_INIT: begin
          if (slice_end)                          state_d = S_FLUSH;
          else if (accept && blks_q == INIT_DLY)  state_d = S_STEADY;
        end
        S_STEADY: if (slice_end) state_d = S_FLUSH;
        S_FLUSH:  if (flush_res == 16'd0) state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    full_d = base_full;
    blks_d = base_blks;
    pix_d  = base_pix;
    ovf_d  = base_ovf;
    pad_d  = '0;
    udf_d  = 1'b0;
    done_d = 1'b0;
    res    = '0;
    if (accept) begin
      if (sum >= drain) begin
        res = sum - drain;
      end else begin
        pad_d = 10'(drain - sum);
        udf_d = 1'b1;
      end
      if (res > {1'b0, BUF_SIZE}) ovf_d = 1'b1;
      full_d = res[16] ? 16'hFFFF : res[15:0];
      blks_d = base_blks + 16'd1;
      pix_d  = base_pix + 16'd16;
    end else if (state_q == S_FLUSH && !slice_start) begin
      full_d = flush_res;
      done_d = (flush_res == 16'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= '0;
      blks_q <= '0;
      pix_q  <= '0;
      pad_q  <= '0;
      udf_q  <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      full_q <= full_d;
      blks_q <= blks_d;
      pix_q  <= pix_d;
      pad_q  <= pad_d;
      udf_q  <= udf_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
    end
  end

`ifdef ENC_BUF_SLICE_BITS_EN
  logic [31:0] acc_q, acc_d;

  always_comb begin
    acc_d = slice_start ? 32'd0 : acc_q;
    if (accept) acc_d = acc_d + {22'd0, curBlkBits};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign m_sliceBitsCur = acc_q;
`else
  assign m_sliceBitsCur = 32'd0;
`endif

  assign m_bufferFullness = full_q;
  assign m_numBlocksCoded = blks_q;
  assign m_numPixelsCoded = pix_q;
  assign padBits          = pad_q;
  assign underflow        = udf_q;
  assign overflow         = ovf_q;
  assign flush_done       = done_q;
  assign busy             = (state_q != S_IDLE);

endmodule

// File: doc/enc_buffer_fullness.md
# enc_buffer_fullness

Encoder-side rate-buffer model for the VDC-M datapath, the mirror of the decoder buffer-fullness tracker. On each coded block it accumulates the block's bit count and drains a fixed average once the initial transmission delay has elapsed, so the encoder's fullness matches the decoder's block for block. It also flags underflow (reporting the pad bits required) and overflow, and drains the residual fullness at slice end. It sits between the block bit-count generator and rate control.

## Interface
Parameters:
- AVE_BLK_BITS, 128: bits drained per block once draining starts.
- INIT_DELAY_BLKS, 64: number of block indices with no drain (pre-increment count ≤ this value).
- BUF_SIZE, 16'd8192: overflow threshold, in bits.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- slice_start  in  1  pulse; clears all slice state.
- blk_valid  in  1  pulse; one block coded this cycle.
- curBlkBits  in  10  bits of the current block; sampled when blk_valid=1.
- slice_end  in  1  pulse; begins the flush.
- m_bufferFullness  out  16  registered fullness, in bits.
- m_numPixelsCoded  out  16  registered count; +16 per block.
- m_numBlocksCoded  out  16  registered block count.
- padBits  out  10  pad bits inserted this cycle to avoid underflow.
- underflow  out  1  one-cycle pulse; padding occurred.
- overflow  out  1  sticky; fullness exceeded BUF_SIZE.
- flush_done  out  1  one-cycle pulse; flush complete.
- busy  out  1  high when the FSM is not in IDLE.
- m_sliceBitsCur  out  32  slice bit accumulator (see Configuration).

## Operation
- FSM states: IDLE, INIT, STEADY, FLUSH.
  - IDLE to INIT on slice_start.
  - INIT to STEADY on the block for which the pre-increment m_numBlocksCoded equals INIT_DELAY_BLKS. Blocks 0..64 (65 blocks) are not drained, matching the decoder's numPixelsCoded ≤ 1024 rule.
  - INIT or STEADY to FLUSH on slice_end.
  - FLUSH to IDLE when fullness reaches 0; flush_done pulses in that cycle.
- On blk_valid in INIT or STEADY:
  - sum = m_bufferFullness + curBlkBits. The sum is 17 bits wide; no truncation before the compare.
  - drain = AVE_BLK_BITS if the pre-increment m_numBlocksCoded > INIT_DELAY_BLKS, else 0.
  - If sum ≥ drain: fullness ← sum − drain, padBits ← 0.
  - Else: fullness ← 0, padBits ← drain − sum, underflow pulses.
  - If the result exceeds BUF_SIZE: overflow is set and stays set until slice_start or rst. Fullness saturates at 16'hFFFF.
  - Counters advance: blocks +1, pixels +16; each wraps at 2^16.
- FLUSH:
  - Each cycle, fullness ← fullness − AVE_BLK_BITS, clamped at 0.
  - No padBits and no underflow are generated during flush.
  - blk_valid is ignored.
- blk_valid in IDLE is ignored.
- slice_start has priority over everything except rst. It clears fullness, counters, overflow and the slice accumulator, then enters INIT.
  - If blk_valid is high in the same cycle, that block is counted as block 0 of the new slice, starting from fullness 0.
- slice_end together with blk_valid: the block is processed first, and the FSM enters FLUSH in the same edge.

## Timing
- All outputs are registered; state updates one cycle after blk_valid or slice_start is sampled.
- padBits and underflow are valid in the cycle after the offending blk_valid, for exactly one cycle.
- Flush latency: ceil(F / AVE_BLK_BITS) cycles after the slice_end edge, where F is the fullness at that edge. With F=0, flush_done occurs on the first cycle in FLUSH.
- Reset values:
  - All outputs are 0 and the FSM is in IDLE.
  - A reset asserted mid-slice or mid-flush aborts immediately with no flush_done pulse.

## Configuration
- ENC_BUF_SLICE_BITS_EN defined:
  - m_sliceBitsCur accumulates curBlkBits (zero-extended) on every accepted block.
  - It is cleared by slice_start or rst and wraps at 2^32.
- ENC_BUF_SLICE_BITS_EN undefined: m_sliceBitsCur is tied to 0 and no accumulator register exists.

## Test plan
- Init window: slice_start, then 65 blocks of 100 bits → fullness = 6500, pixels = 1040, state STEADY. Next block of 100 bits → fullness = 6472.
- Underflow: after init, drive fullness to 50, then a block of 20 bits → fullness 0, padBits = 58, underflow high for 1 cycle.
- Overflow: BUF_SIZE = 1000, 11 blocks of 100 bits in INIT → overflow set at fullness 1100; it stays set through later blocks and clears only on slice_start.
- Flush: fullness 300, slice_end → fullness 172, 44, 0 on successive cycles; flush_done on the third cycle; busy low afterward.
- Simultaneous events:
  - slice_start + blk_valid with curBlkBits = 37 → fullness 37, blocks 1, overflow cleared.
  - slice_end + blk_valid → block accumulated, then the flush proceeds.
- Reset and macro:
  - rst mid-flush → all outputs 0, no flush_done.
  - With ENC_BUF_SLICE_BITS_EN, 3 blocks of 200 bits → m_sliceBitsCur = 600; without the macro it stays 0.
